// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point adder: operand classes, flag
// bit positions and helpers for exponent bias and the canonical quiet NaN.
package fpu_pkg;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    typedef enum logic [1:0] {
        ZERO = 2'd0,
        NORM = 2'd1,
        INF  = 2'd2,
        NAN  = 2'd3
    } fp_class_e;

    function automatic int bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Sign 0, exponent all ones, fraction MSB set; caller truncates to its word width.
    function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
        return ((((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1)));
    endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module fpu_lzc #(
    parameter int WIDTH = 27
) (
    input  logic [WIDTH-1:0]               in_i,
    output logic [$clog2(WIDTH+1)-1:0]     cnt_o
);
    localparam int CW = $clog2(WIDTH + 1);

    // Scanning upward lets the highest set bit overwrite any lower hit.
    always_comb begin
        cnt_o = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (in_i[i]) begin
                cnt_o = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fpu_pipelined_adder.sv
// Four-stage IEEE-754 adder/subtractor: unpack/compare, align, add, normalise/round/pack.
// Subnormal inputs flush to zero; results below the normal range flush to signed zero.
module fpu_pipelined_adder
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [EXP_W+MAN_W:0]         in_a,
    input  logic [EXP_W+MAN_W:0]         in_b,
    input  logic                         in_sub,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [EXP_W+MAN_W:0]         out_result,
    output logic [3:0]                   out_flags
);
    localparam int W   = 1 + EXP_W + MAN_W;
    localparam int AW  = MAN_W + 4;
    localparam int SW  = MAN_W + 5;
    localparam int XW  = EXP_W + 2;
    localparam int LZW = $clog2(AW + 1);
    localparam logic [W-1:0] QNAN = W'(qnan_bits(EXP_W, MAN_W));

    logic adv;

    logic               s1_valid_q, s1_spc_q, s1_inv_q, s1_sign_q, s1_esub_q;
    logic [W-1:0]       s1_spc_res_q;
    logic [EXP_W-1:0]   s1_exp_q, s1_diff_q;
    logic [MAN_W:0]     s1_big_q, s1_sml_q;

    logic               s2_valid_q, s2_spc_q, s2_inv_q, s2_sign_q, s2_esub_q;
    logic [W-1:0]       s2_spc_res_q;
    logic [EXP_W-1:0]   s2_exp_q;
    logic [AW-1:0]      s2_big_q, s2_sml_q;

    logic               s3_valid_q, s3_spc_q, s3_inv_q, s3_sign_q;
    logic [W-1:0]       s3_spc_res_q;
    logic [XW-1:0]      s3_exp_q;
    logic [SW-1:0]      s3_sum_q;

    logic               out_valid_q;
    logic [W-1:0]       out_result_q;
    logic [3:0]         out_flags_q;

    assign adv        = !out_valid_q | out_ready;
    assign in_ready   = adv;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

    logic               a_sgn, b_sgn, a_big;
    logic [EXP_W-1:0]   a_exp, b_exp;
    logic [MAN_W-1:0]   a_man, b_man;
    fp_class_e          a_cls, b_cls;

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
        if (e == '0)      return ZERO;
        else if (&e)      return (m == '0) ? INF : NAN;
        else              return NORM;
    endfunction

    assign a_sgn = in_a[W-1];
    assign b_sgn = in_b[W-1] ^ in_sub;
    assign a_exp = in_a[W-2:MAN_W];
    assign b_exp = in_b[W-2:MAN_W];
    assign a_man = in_a[MAN_W-1:0];
    assign b_man = in_b[MAN_W-1:0];
    assign a_cls = classify(a_exp, a_man);
    assign b_cls = classify(b_exp, b_man);
    assign a_big = {a_exp, a_man} >= {b_exp, b_man};

    logic               s1_spc_d, s1_inv_d;
    logic [W-1:0]       s1_spc_res_d;

    always_comb begin
        s1_spc_d     = 1'b1;
        s1_inv_d     = 1'b0;
        s1_spc_res_d = '0;
        if (a_cls == NAN || b_cls == NAN || (a_cls == INF && b_cls == INF && a_sgn != b_sgn)) begin
            s1_spc_res_d = QNAN;
            s1_inv_d     = 1'b1;
        end else if (a_cls == INF) begin
            s1_spc_res_d = {a_sgn, in_a[W-2:0]};
        end else if (b_cls == INF) begin
            s1_spc_res_d = {b_sgn, in_b[W-2:0]};
        end else if (a_cls == ZERO && b_cls == ZERO) begin
            s1_spc_res_d = {a_sgn & b_sgn, {(W-1){1'b0}}};
        end else if (a_cls == ZERO) begin
            s1_spc_res_d = {b_sgn, in_b[W-2:0]};
        end else if (b_cls == ZERO) begin
            s1_spc_res_d = in_a;
        end else begin
            s1_spc_d = 1'b0;
        end
    end

    logic [AW-1:0] s2_ext, s2_shf, s2_mask, s2_sml_d;

    // Anything shifted past the sticky position only matters as "nonzero".
    always_comb begin
        s2_ext   = {s1_sml_q, 3'b000};
        s2_shf   = '0;
        s2_mask  = '0;
        s2_sml_d = AW'(1);
        if (32'(s1_diff_q) < (MAN_W + 3)) begin
            s2_shf   = s2_ext >> s1_diff_q;
            s2_mask  = ~({AW{1'b1}} << s1_diff_q);
            s2_sml_d = {s2_shf[AW-1:1], s2_shf[0] | (|(s2_ext & s2_mask))};
        end
    end

    logic [SW-1:0] s3_sum_d;

    assign s3_sum_d = s2_esub_q ? ({1'b0, s2_big_q} - {1'b0, s2_sml_q})
                                : ({1'b0, s2_big_q} + {1'b0, s2_sml_q});

    logic [LZW-1:0]   s4_lz;
    logic [AW-1:0]    s4_norm;
    logic [XW-1:0]    s4_exp_n, s4_exp_r;
    logic [MAN_W+1:0] s4_rnd;
    logic [MAN_W-1:0] s4_frac;
    logic             s4_inc, s4_inx, s4_ovf, s4_unf;
    logic [W-1:0]     res_d;
    logic [3:0]       flags_d;

    fpu_lzc #(.WIDTH(AW)) u_lzc (
        .in_i  (s3_sum_q[AW-1:0]),
        .cnt_o (s4_lz)
    );

    always_comb begin
        if (s3_sum_q[SW-1]) begin
            s4_norm  = {s3_sum_q[SW-1:2], s3_sum_q[1] | s3_sum_q[0]};
            s4_exp_n = s3_exp_q + XW'(1);
        end else begin
            s4_norm  = s3_sum_q[AW-1:0] << s4_lz;
            s4_exp_n = s3_exp_q - XW'(s4_lz);
        end
        s4_inc = s4_norm[2] & (s4_norm[1] | s4_norm[0] | s4_norm[3]);
        s4_inx = s4_norm[2] | s4_norm[1] | s4_norm[0];
        s4_rnd = {1'b0, s4_norm[AW-1:3]} + (MAN_W+2)'(s4_inc);
        if (s4_rnd[MAN_W+1]) begin
            s4_frac  = s4_rnd[MAN_W:1];
            s4_exp_r = s4_exp_n + XW'(1);
        end else begin
            s4_frac  = s4_rnd[MAN_W-1:0];
            s4_exp_r = s4_exp_n;
        end
        s4_ovf = !s4_exp_r[XW-1] && (s4_exp_r[XW-2:0] >= (XW-1)'((1 << EXP_W) - 1));
        s4_unf = s4_exp_r[XW-1] || (s4_exp_r == '0);
    end

    always_comb begin
        res_d   = '0;
        flags_d = '0;
        if (s3_spc_q) begin
            res_d            = s3_spc_res_q;
            flags_d[FLG_INV] = s3_inv_q;
        end else if (s3_sum_q == '0) begin
            res_d = '0;
        end else if (s4_ovf) begin
            res_d            = {s3_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d[FLG_OVF] = 1'b1;
            flags_d[FLG_INX] = 1'b1;
        end else if (s4_unf) begin
            res_d            = {s3_sign_q, {(W-1){1'b0}}};
            flags_d[FLG_UNF] = 1'b1;
            flags_d[FLG_INX] = 1'b1;
        end else begin
            res_d            = {s3_sign_q, s4_exp_r[EXP_W-1:0], s4_frac};
            flags_d[FLG_INX] = s4_inx;
        end
    end

    // All stages move in lockstep on adv; bubbles travel like transactions.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s2_valid_q   <= 1'b0;
            s3_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else if (adv) begin
            s1_valid_q   <= in_valid;
            s1_spc_q     <= s1_spc_d;
            s1_inv_q     <= s1_inv_d;
            s1_spc_res_q <= s1_spc_res_d;
            s1_sign_q    <= a_big ? a_sgn : b_sgn;
            s1_esub_q    <= a_sgn ^ b_sgn;
            s1_exp_q     <= a_big ? a_exp : b_exp;
            s1_diff_q    <= a_big ? (a_exp - b_exp) : (b_exp - a_exp);
            s1_big_q     <= a_big ? {1'b1, a_man} : {1'b1, b_man};
            s1_sml_q     <= a_big ? {1'b1, b_man} : {1'b1, a_man};

            s2_valid_q   <= s1_valid_q;
            s2_spc_q     <= s1_spc_q;
            s2_inv_q     <= s1_inv_q;
            s2_spc_res_q <= s1_spc_res_q;
            s2_sign_q    <= s1_sign_q;
            s2_esub_q    <= s1_esub_q;
            s2_exp_q     <= s1_exp_q;
            s2_big_q     <= {s1_big_q, 3'b000};
            s2_sml_q     <= s2_sml_d;

            s3_valid_q   <= s2_valid_q;
            s3_spc_q     <= s2_spc_q;
            s3_inv_q     <= s2_inv_q;
            s3_spc_res_q <= s2_spc_res_q;
            s3_sign_q    <= s2_sign_q;
            s3_exp_q     <= {2'b00, s2_exp_q};
            s3_sum_q     <= s3_sum_d;

            out_valid_q  <= s3_valid_q;
            out_result_q <= res_d;
            out_flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_fpu_pipelined_adder.sv
// Bench for the pipelined single-precision adder: directed vectors, stall and
// reset sequences, and a randomized stream against an exact-arithmetic model.
module tb_fpu_pipelined_adder;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_sub, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [3:0]  out_flags;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fpu_pipelined_adder #(.EXP_W(8), .MAN_W(23)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Exact sum as a wide integer, then round-to-nearest-even to 24 significant bits.
    function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic sa, sb, sB, sS;
        int ea, eb, eB, eS, d, p, e, sh;
        logic [22:0] fa, fb;
        logic [23:0] mB, mS;
        logic [127:0] x, y, r, keep, rem, half;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inx;
        sa = a[31];
        sb = b[31] ^ sub;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        a_nan  = (ea == 255) && (fa != 0);
        b_nan  = (eb == 255) && (fb != 0);
        a_inf  = (ea == 255) && (fa == 0);
        b_inf  = (eb == 255) && (fb == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_inf && sa != sb)) return {4'b1000, 32'h7FC00000};
        if (a_inf) return {4'h0, sa, a[30:0]};
        if (b_inf) return {4'h0, sb, b[30:0]};
        if (a_zero && b_zero) return {4'h0, sa & sb, 31'h0};
        if (a_zero) return {4'h0, sb, b[30:0]};
        if (b_zero) return {4'h0, a};
        if (ea > eb || (ea == eb && fa >= fb)) begin
            eB = ea; mB = {1'b1, fa}; sB = sa; eS = eb; mS = {1'b1, fb}; sS = sb;
        end else begin
            eB = eb; mB = {1'b1, fb}; sB = sb; eS = ea; mS = {1'b1, fa}; sS = sa;
        end
        d = eB - eS;
        x = {104'd0, mB} << 64;
        y = (d <= 64) ? ({104'd0, mS} << (64 - d)) : 128'd1;
        r = (sB == sS) ? x + y : x - y;
        if (r == 0) return {4'h0, 32'h0};
        p = 127;
        while (!r[p]) p--;
        e    = eB + p - 87;
        sh   = p - 23;
        keep = r >> sh;
        rem  = r - (keep << sh);
        half = 128'd1 << (sh - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && keep[0])) keep = keep + 128'd1;
        if (keep[24]) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= 255) return {4'b0101, sB, 8'hFF, 23'h0};
        if (e <= 0)   return {4'b0011, sB, 31'h0};
        return {3'b000, inx, sB, e[7:0], keep[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        int k;
        v = $urandom;
        k = $urandom_range(0, 19);
        if (k == 0)      v[30:0]  = '0;
        else if (k == 1) v[30:0]  = {8'hFF, 23'h0};
        else if (k == 2) v[30:23] = 8'hFF;
        else if (k == 3) v[30:23] = 8'h00;
        else if (k == 4) v[30:23] = 8'hFE;
        else if (k == 5) v[30:23] = 8'($urandom_range(1, 4));
        else if (k < 14) v[30:23] = 8'($urandom_range(110, 140));
        return v;
    endfunction

    task automatic one_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          output logic [31:0] r, output logic [3:0] f, output int lat);
        @(posedge clk); #1;
        in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        r = out_result;
        f = out_flags;
    endtask

    task automatic stream(input int n, input bit stall_test);
        logic [31:0] qa[$], qb[$];
        logic        qs[$];
        logic [35:0] exp_q[$];
        logic [35:0] hold_val;
        logic [31:0] a, b;
        bit          hold_pend;
        int          sent, got, cyc, stall_low;
        sent = 0; got = 0; cyc = 0; stall_low = 0; hold_pend = 0; hold_val = '0;
        for (int i = 0; i < n; i++) begin
            a = rand_op();
            if ($urandom_range(0, 3) == 0) b = {1'($urandom_range(0, 1)), a[30:0] ^ 31'($urandom_range(0, 15))};
            else b = rand_op();
            qa.push_back(a);
            qb.push_back(b);
            qs.push_back(1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a = qa[0]; in_b = qb[0]; in_sub = qs[0];
        while (got < n && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (hold_pend) chk($sformatf("hold_c%0d", cyc), {out_valid, out_flags, out_result}, {1'b1, hold_val});
            hold_pend = out_valid && !out_ready;
            hold_val  = {out_flags, out_result};
            if (stall_test) begin
                chk($sformatf("in_ready_c%0d", cyc), in_ready, !out_valid || out_ready);
                if (!out_ready) begin
                    chk($sformatf("in_ready_stall_c%0d", cyc), in_ready, 1'b0);
                    stall_low++;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("extra_result", 64'(exp_q.size()), 64'd1);
                else chk($sformatf("result_%0d", got), {out_flags, out_result}, exp_q.pop_front());
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add(in_a, in_b, in_sub));
                sent++;
            end
            @(posedge clk); #1;
            in_valid = (sent < n) && (stall_test || $urandom_range(0, 4) != 0);
            if (sent < n) begin
                in_a = qa[sent]; in_b = qb[sent]; in_sub = qs[sent];
            end
            out_ready = stall_test ? !(cyc >= 6 && cyc <= 8) : ($urandom_range(0, 3) != 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", 64'(got), 64'(n));
        if (stall_test) chk("stall_cycles", 64'(stall_low), 64'd3);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic [3:0]  flg;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        int          lat, stale;

        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0};
        vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0};
        vecs[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1};
        vecs[3]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1};
        vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5};
        vecs[5]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h8};
        vecs[6]  = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0};
        vecs[7]  = '{32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'h0};
        vecs[8]  = '{32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'h0};
        vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0};
        vecs[10] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'h0};
        vecs[11] = '{32'h7F800001, 32'h00000000, 1'b0, 32'h7FC00000, 4'h8};
        vecs[12] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'h0};
        vecs[13] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0};
        vecs[14] = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h3};
        vecs[15] = '{32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 4'h0};
        vecs[16] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8};
        vecs[17] = '{32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 4'h5};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_sub = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_flags", out_flags, 4'h0);
        chk("rst_in_ready", in_ready, 1'b1);

        for (int i = 0; i < NV; i++) begin
            one_op(vecs[i].a, vecs[i].b, vecs[i].sub, r, f, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("vec%0d_result", i), r, vecs[i].res);
            chk($sformatf("vec%0d_flags", i), f, vecs[i].flg);
        end

        stream(8, 1'b1);

        // Reset while transactions are in flight must drop all of them.
        @(posedge clk); #1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_a = rand_op(); in_b = 32'h3F800000; in_sub = 1'b0;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_out_valid", out_valid, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_out_result", out_result, 32'h0);
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("post_rst_stale", 64'(stale), 64'd0);
        one_op(vecs[15].a, vecs[15].b, vecs[15].sub, r, f, lat);
        chk("post_rst_latency", 64'(lat), 64'd4);
        chk("post_rst_result", {f, r}, {vecs[15].flg, vecs[15].res});

        stream(300, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule

// File: doc/fpu_pipelined_adder.md
Name: fpu_pipelined_adder

Overview:
- Parametrised, 4-stage pipelined IEEE-754 floating-point adder/subtractor with valid/ready handshakes on both sides.
- Successor to the combinational single-precision adder. Adds:
  - selectable exponent/mantissa widths
  - add/subtract mode
  - round-to-nearest-even
  - special-value handling
  - separate exception flags
- Sits between the FPU operand issue logic and the result writeback/arbiter.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
- MAN_W, 23, stored mantissa (fraction) width; total word W = 1+EXP_W+MAN_W

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_sub  in  1  0: A+B, 1: A-B (B sign inverted at stage 1)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_result  out  W  packed result
- out_flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset and clock:
  - Single clock, clk. Synchronous active-high reset, rst.
  - On rst: all stage valid bits cleared; out_valid=0, out_result=0, out_flags=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards every in-flight transaction.
- Handshake and stalls:
  - Pipeline enable: adv = !out_valid | out_ready. All four stages shift together when adv=1 and hold when adv=0.
  - in_ready = adv, combinational; no combinational in_valid→in_ready path.
  - Transfer on in_valid & in_ready.
  - out_result/out_flags stay stable while out_valid=1 & out_ready=0.
  - Bubbles are not compressed.
  - Latency: exactly 4 cycles from accept to out_valid when never stalled.
  - Throughput: 1 per cycle.
- S1 unpack/compare:
  - Apply in_sub to B's sign.
  - Classify each operand: zero (exp=0, subnormals flushed to zero), inf, NaN, normal.
  - Form significands with hidden 1, width MAN_W+1.
  - Swap so the operand with larger {exp,mantissa} is "big"; compute exp_diff.
- S2 align:
  - Shift small significand right by exp_diff into MAN_W+4 bits (guard, round, sticky).
  - Sticky = OR of all bits shifted out.
  - exp_diff ≥ MAN_W+3 → small becomes sticky only.
- S3 add/sub:
  - Equal effective signs: add.
  - Otherwise: big − small; non-negative by construction.
  - Result sign = big sign.
  - Exact zero from subtraction gives +0 (−0 only if both operands are −0).
- S4 normalise/round/pack:
  - Carry-out: shift right 1 (sticky absorbs the lost bit), exp+1.
  - Otherwise: leading-zero count, shift left, exp−LZC.
  - RNE round: increment if G & (R|S|LSB). Renormalise on mantissa overflow.
  - inexact = G|R|S.
  - exp ≥ 2^EXP_W−1 → ±inf, overflow=1, inexact=1.
  - exp ≤ 0 → signed zero, underflow=1, inexact=1.
- Specials, which override the computed result:
  - any NaN or (inf + −inf effective) → canonical qNaN (sign 0, exp all ones, fraction MSB 1), invalid=1
  - inf with finite → that inf
  - zero with x → x
  - Special-case flags: only invalid, as above.
- Width rules:
  - Internal datapath width MAN_W+5 (carry, hidden, G, R, S).
  - Exponent path EXP_W+2 signed.

Decomposition:
- Shared package fpu_pkg:
  - bias function
  - qNaN constant builder
  - flag bit indices (FLG_INV=3, FLG_OVF=2, FLG_UNF=1, FLG_INX=0)
  - operand class enum (ZERO, NORM, INF, NAN)
- One sub-module: fpu_lzc (parametrised leading-zero counter, WIDTH, output $clog2(WIDTH+1) bits), used in S4.
- Alignment shift and rounding stay inline.

Test Plan (defaults, single precision):
- 0x3F800000 + 0x3F800000, in_sub=0 → after exactly 4 cycles 0x40000000, flags 0000.
- 0x3F800000 − 0x3F800000 (in_sub=1) → 0x00000000, flags 0000.
- RNE tie and sticky:
  - 0x3F800000 + 0x33800000 → 0x3F800000, inexact=1.
  - 0x3F800001 + 0x33800000 → 0x3F800002, inexact=1.
- Overflow, invalid and denormal flush:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, overflow=1, inexact=1.
  - 0x7F800000 + 0xFF800000 → 0x7FC00000, invalid=1.
  - 0x00000001 + 0x3F800000 → 0x3F800000.
- Back-to-back stream of 8 pairs with out_ready low for 3 cycles mid-stream:
  - in_ready drops the same cycles.
  - Results arrive in order, none lost or duplicated, output held stable while stalled.
  - rst asserted mid-stream → out_valid=0 next cycle and no stale results afterward.
